// File: rtl/count_capture_if.sv
// count_capture_if: valid/ready stream carrying capture deltas downstream.
//   master: drives out_data/out_valid, samples out_ready (the capture stage)
//   slave : samples out_data/out_valid, drives out_ready (the consumer)
interface count_capture_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/count_capture.sv
// count_capture: synchronise an async event, timestamp it against a free-running
// counter, and queue the elapsed count since the previous event.
//   clk, reset : clock, synchronous active-high reset
//   count_in   : current counter value
//   event_in   : asynchronous event, rising edge triggers a capture
//   out_if     : delta stream (out_data/out_valid/out_ready)
//   overflow   : sticky, a capture was dropped on a full FIFO
//   clear_ovf  : clears overflow (a same-cycle drop wins)
//   level      : FIFO occupancy 0..DEPTH
module count_capture #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         count_in,
  input  logic                     event_in,
  count_capture_if.master          out_if,
  output logic                     overflow,
  input  logic                     clear_ovf,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  logic [2:0]       sync_q;
  logic [WIDTH-1:0] prev_q, prev_d, delta;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      level_q, level_d;
  logic             ovf_q, ovf_d;
  logic             rise, full, pop, push, drop;
  always_comb begin
    rise    = sync_q[1] & ~sync_q[2];
    full    = level_q == FULL_LVL;
    pop     = (level_q != '0) & out_if.out_ready;
    // a full FIFO still accepts a push when its head leaves on the same edge
    push    = rise & (~full | pop);
    drop    = rise & full & ~pop;
    delta   = count_in - prev_q;
    prev_d  = rise ? count_in : prev_q;
    wr_d    = push ? wr_q + AW'(1) : wr_q;
    rd_d    = pop ? rd_q + AW'(1) : rd_q;
    level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);
    ovf_d   = drop | (ovf_q & ~clear_ovf);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      prev_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sync_q  <= {sync_q[1:0], event_in};
      prev_q  <= prev_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      if (push) mem_q[wr_q] <= delta;
    end
  end
  assign out_if.out_data  = mem_q[rd_q];
  assign out_if.out_valid = level_q != '0;
  assign level            = level_q;
  assign overflow         = ovf_q;
endmodule

// File: doc/count_capture.md
# count_capture

Timestamp capture stage fed directly by the free-running `counter` output. Synchronises an asynchronous event input, samples the counter value on each event rising edge, and computes the elapsed count since the previous capture (modulo 2^WIDTH). Deltas are buffered in a small FIFO and handed downstream over a valid/ready handshake, with a sticky overflow flag for dropped captures.

## Interface
- `WIDTH`, 8: width of `count_in` and `out_data`; must match the counter width.
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.

- `clk`  input  1: single clock; all state updates on rising edge.
- `reset`  input  1: synchronous, active-high reset.
- `count_in`  input  WIDTH: current counter value (counter `out`).
- `event_in`  input  1: asynchronous event; rising edge triggers a capture.
- `out_data`  output  WIDTH: delta at FIFO head.
- `out_valid`  output  1: FIFO non-empty.
- `out_ready`  input  1: downstream accepts head when `out_valid & out_ready`.
- `overflow`  output  1: sticky; a capture was dropped because the FIFO was full.
- `clear_ovf`  input  1: clears `overflow`.
- `level`  output  $clog2(DEPTH)+1: FIFO occupancy, 0..DEPTH.

## Operation
- Synchroniser: three flops `s1<=event_in`, `s2<=s1`, `s3<=s2`; `rise = s2 & ~s3`.
- Capture: on a clock edge with `rise=1`, compute `delta = count_in - prev` (WIDTH-bit, wrap-around, no saturation). Push `delta`. Set `prev <= count_in`.
- `prev` updates on every capture, including dropped ones. The next delta is always measured from the most recent event.
- First capture after reset: `prev` is 0, so delta equals the sampled `count_in`.
- FIFO: circular buffer, DEPTH entries. `out_data` is driven from the head entry, registered storage, no combinational path from `count_in`.
- Pop on `out_valid & out_ready`. `out_ready` while empty has no effect.
- Push when full without a pop in the same cycle: the push is dropped, FIFO contents are unchanged, and `overflow <= 1`.
- Push when full with a pop in the same cycle: both occur. `level` stays DEPTH and `overflow` is not set.
- Push and pop in the same cycle when not full: both occur, and `level` is unchanged.
- `overflow`: `clear_ovf` clears it. If `clear_ovf` and a new drop occur in the same cycle, `overflow` is 1 (set wins).
- Reset, including mid-operation: s1/s2/s3=0, `prev`=0, FIFO emptied (pointers 0), `overflow`=0. Pending entries are discarded.
- If `event_in` is held high across reset release, it is treated as a rising edge and produces one capture.

## Timing
- Reset values: `out_valid`=0, `level`=0, `overflow`=0. `out_data` is don't-care while `out_valid`=0, and is 0 after reset.
- Event latency: `event_in` rises before edge E0. Then s1=1 after E0, s2=1 after E1, `rise` is high in the E1–E2 cycle, and the push happens at E2. The captured `count_in` is the value sampled at E2.
- `out_valid` goes high after E2 if the FIFO was empty. There is no bypass path.
- Minimum event spacing: `event_in` must be low for at least 2 clocks between rises. Shorter pulses may be missed and are not required to be captured.
- `level`, `out_valid`, and `overflow` are registered and update on the same edge as the push or pop.
- Throughput: one push and one pop per cycle.

## Test plan
- Reset / first capture (WIDTH=8): the counter runs from 0 after reset release, with an event whose push edge samples `count_in`=37. Required: `out_data`=37, `out_valid`=1, `level`=1.
- Delta and wrap: captures at `count_in`=250, then 4 (the counter has wrapped). Required: the second `out_data`=10 (4−250 mod 256). With a third capture at 4 again after exactly 256 clocks, required `out_data`=0.
- Full / overflow: with `out_ready`=0, send 5 events (DEPTH=4). Required: `level`=4, `overflow`=1, and the FIFO holds the first 4 deltas. Then `out_ready`=1 drains them in order, and the 6th capture's delta is measured from the 5th (dropped) event's count.
- Full with simultaneous push and pop: FIFO full, `out_ready`=1, and an event pushes in the same cycle. Required: `level` stays 4, `overflow` stays 0, and the new delta appears as the last entry.
- Overflow clear race: `clear_ovf`=1 in the same cycle as a dropped push. Required: `overflow`=1. `clear_ovf`=1 alone on the next cycle gives `overflow`=0.
- Reset mid-operation: assert `reset` for 1 cycle with `level`=3 and `overflow`=1. Required: `level`=0, `out_valid`=0, `overflow`=0 after the edge. The next capture outputs `out_data` equal to raw `count_in` (since `prev`=0).
